cr_prefix_rec_topk: RTL and testbench

- Parametrised successor to the recogniser output/decision stage.
- Snapshots one activation vector of N_NEURONS signed results, scans it LANES neurons per cycle, and keeps a sorted top-K list of enabled neurons above a signed threshold.
- Emits the winning neuron indices, one word per cycle, into the prefix FIFO under pf_full backpressure.
- Adds configurable neuron count, scan width and K, a no-match code, a hold freeze and an error pulse.

---
 rtl/cr_prefix_rec_topk_if.sv | 10 +
 rtl/cr_prefix_rec_topk.sv | 162 ++++++++++++++++
 tb/tb_cr_prefix_rec_topk.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cr_prefix_rec_topk_if.sv
// Prefix FIFO write port of the recogniser top-K decision stage.
// The decision stage drives the master side; the FIFO drives the slave side.
interface cr_prefix_rec_topk_if;
    logic       pf_full;
    logic       rec_us_prefix_valid;
    logic [8:0] rec_us_pf_datain;

    modport master (input pf_full, output rec_us_prefix_valid, output rec_us_pf_datain);
    modport slave  (output pf_full, input rec_us_prefix_valid, input rec_us_pf_datain);
endinterface

// File: rtl/cr_prefix_rec_topk.sv
// Recogniser decision stage: snapshots an activation vector, scans it LANES neurons
// per cycle into a sorted top-K list, then writes the winners into the prefix FIFO.
module cr_prefix_rec_topk #(
    parameter int N_NEURONS = 128,
    parameter int LANES     = 8,
    parameter int TOPK      = 4,
    parameter int ACT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rec_topk_start,
    input  logic [N_NEURONS*ACT_W-1:0] rec_act_result,
    input  logic [N_NEURONS-1:0]       rec_neuron_en,
    input  logic [ACT_W-1:0]           rec_threshold,
    input  logic                       rec_us_hold,
    cr_prefix_rec_topk_if.master       pf,
    output logic                       rec_topk_busy,
    output logic                       rec_topk_done,
    output logic                       rec_topk_err,
    output logic [TOPK*8-1:0]          rec_topk_idx,
    output logic [TOPK*ACT_W-1:0]      rec_topk_val,
    output logic [3:0]                 rec_topk_cnt
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int S     = N_NEURONS / LANES;
    localparam int C_W   = (S > 1) ? $clog2(S) : 1;
    localparam int P_W   = (TOPK > 1) ? $clog2(TOPK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t                  state_q, state_d;
    logic signed [ACT_W-1:0] act_snap [N_NEURONS];
    logic [N_NEURONS-1:0]    en_snap;
    logic signed [ACT_W-1:0] thr_snap;
    logic [C_W-1:0]          chunk;
    logic [P_W-1:0]          ptr;
    logic [IDX_W-1:0]        list_idx [TOPK];
    logic signed [ACT_W-1:0] list_val [TOPK];
    logic [3:0]              list_cnt;
    logic [IDX_W-1:0]        nxt_idx [TOPK];
    logic signed [ACT_W-1:0] nxt_val [TOPK];
    logic [3:0]              nxt_cnt;
    logic                    accept, strobe, last_word;
    logic [8:0]              datain;

    // Insertion chain over one chunk; strict '>' keeps the earlier (lower) index ahead on ties.
    always_comb begin : insert_chain
        logic [IDX_W-1:0]        nidx;
        logic signed [ACT_W-1:0] cand;
        int                      pos;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_idx = list_idx;
        nxt_val = list_val;
        nxt_cnt = list_cnt;
        nidx    = '0;
        cand    = '0;
        pos     = TOPK;
        for (int l = 0; l < LANES; l++) begin
            nidx = IDX_W'(int'(chunk) * LANES + l);
            cand = act_snap[nidx];
            if (en_snap[nidx] && cand > thr_snap) begin
                pos = TOPK;
                for (int j = TOPK - 1; j >= 0; j--)
                    if (j >= int'(nxt_cnt) || cand > nxt_val[j]) pos = j;
                for (int j = TOPK - 1; j > 0; j--)
                    if (j > pos) begin
                        nxt_idx[j] = nxt_idx[j-1];
                        nxt_val[j] = nxt_val[j-1];
                    end
                for (int j = 0; j < TOPK; j++)
                    if (j == pos) begin
                        nxt_idx[j] = nidx;
                        nxt_val[j] = cand;
                    end
                if (pos < TOPK && nxt_cnt < 4'(TOPK)) nxt_cnt = nxt_cnt + 4'd1;
            end
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        accept    = 1'b0;
        strobe    = 1'b0;
        last_word = 1'b0;
        datain    = '0;
        unique case (state_q)
            IDLE: if (rec_topk_start && !rec_us_hold) begin
                accept  = 1'b1;
                state_d = SCAN;
            end
            SCAN: if (!rec_us_hold && chunk == C_W'(S - 1)) state_d = EMIT;
            EMIT: begin
                strobe = !pf.pf_full && !rec_us_hold;
                if (list_cnt == 4'd0) begin
                    last_word = 1'b1;
                    datain    = 9'h1FF;
                end else begin
                    last_word = (4'(ptr) == list_cnt - 4'd1);
                    datain    = {last_word, 8'(list_idx[ptr])};
                end
                if (strobe && last_word) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the snapshot is a flop array, not a RAM, so clearing it on reset is legal and intended.
            for (int i = 0; i < N_NEURONS; i++) act_snap[i] <= '0;
            for (int k = 0; k < TOPK; k++) begin
                list_idx[k] <= '0;
                list_val[k] <= '0;
            end
            en_snap       <= '0;
            thr_snap      <= '0;
            list_cnt      <= '0;
            chunk         <= '0;
            ptr           <= '0;
            rec_topk_done <= 1'b0;
            rec_topk_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            rec_topk_err  <= rec_topk_start && rec_topk_busy && !rec_us_hold;
            rec_topk_done <= strobe && last_word;
            if (accept) begin
                for (int i = 0; i < N_NEURONS; i++) act_snap[i] <= rec_act_result[i*ACT_W +: ACT_W];
                for (int k = 0; k < TOPK; k++) begin
                    list_idx[k] <= '0;
                    list_val[k] <= '0;
                end
                en_snap  <= rec_neuron_en;
                thr_snap <= rec_threshold;
                list_cnt <= '0;
                chunk    <= '0;
                ptr      <= '0;
            end else if (state_q == SCAN && !rec_us_hold) begin
                list_idx <= nxt_idx;
                list_val <= nxt_val;
                list_cnt <= nxt_cnt;
                chunk    <= (chunk == C_W'(S - 1)) ? '0 : chunk + C_W'(1);
            end else if (strobe) begin
                ptr <= ptr + P_W'(1);
            end
        end
    end

    assign pf.rec_us_prefix_valid = strobe;
    assign pf.rec_us_pf_datain    = datain;
    assign rec_topk_busy          = (state_q != IDLE);
    assign rec_topk_cnt           = list_cnt;

    for (genvar k = 0; k < TOPK; k++) begin : g_vis
        assign rec_topk_idx[k*8 +: 8]        = 8'(list_idx[k]);
        assign rec_topk_val[k*ACT_W +: ACT_W] = list_val[k];
    end
endmodule

// File: tb/tb_cr_prefix_rec_topk.sv
// Bench for cr_prefix_rec_topk: directed decision cases plus randomized vectors,
// compared with a sort-based top-K and cycle-timeline reference model.
module tb_cr_prefix_rec_topk;
    localparam int N = 64, L = 8, K = 2, W = 8, S = N / L, HORIZON = 48;

    logic           clk = 1'b0;
    logic           rst_n, start, hold;
    logic [N*W-1:0] act_bus;
    logic [N-1:0]   en_bus;
    logic [W-1:0]   thr_bus;
    logic           busy, done, err;
    logic [K*8-1:0] idx_bus;
    logic [K*W-1:0] val_bus;
    logic [3:0]     cnt;

    cr_prefix_rec_topk_if pf_if ();

    cr_prefix_rec_topk #(.N_NEURONS(N), .LANES(L), .TOPK(K), .ACT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .rec_topk_start(start), .rec_act_result(act_bus),
        .rec_neuron_en(en_bus), .rec_threshold(thr_bus), .rec_us_hold(hold), .pf(pf_if),
        .rec_topk_busy(busy), .rec_topk_done(done), .rec_topk_err(err),
        .rec_topk_idx(idx_bus), .rec_topk_val(val_bus), .rec_topk_cnt(cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stimulus description and reference-model state
    logic signed [W-1:0] m_act [N];
    logic [N-1:0]        m_en;
    logic signed [W-1:0] m_thr;
    bit                  full_pat [HORIZON];
    bit                  hold_pat [HORIZON];
    int                  start2, rst_cyc;
    int                  exp_idx [K];
    logic [W-1:0]        exp_val [K];
    int                  exp_cnt;
    int                  s_cyc[$], d_cyc[$], e_cyc[$];
    logic [8:0]          s_dat[$];

    task automatic clear_pats();
        for (int r = 0; r < HORIZON; r++) begin
            full_pat[r] = 1'b0;
            hold_pat[r] = 1'b0;
        end
        start2  = -1;
        rst_cyc = -1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < N; i++) m_act[i] = W'(i - 32);
        m_en  = '1;
        m_thr = '0;
    endtask

    // Top-K by value descending, lower index first on equal values.
    task automatic model_topk();
        bit taken [N];
        int best;
        for (int i = 0; i < N; i++) taken[i] = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (!taken[i] && m_en[i] && m_act[i] > m_thr && (best < 0 || m_act[i] > m_act[best]))
                    best = i;
            if (best >= 0) begin
                taken[best] = 1'b1;
                exp_idx[k]  = best;
                exp_val[k]  = m_act[best];
                exp_cnt++;
            end else begin
                exp_idx[k] = 0;
                exp_val[k] = '0;
            end
        end
    endtask

    task automatic run_case();
        s_cyc.delete(); s_dat.delete(); d_cyc.delete(); e_cyc.delete();
        for (int i = 0; i < N; i++) act_bus[i*W +: W] = m_act[i];
        en_bus  = m_en;
        thr_bus = m_thr;
        for (int r = 0; r < HORIZON; r++) begin
            @(negedge clk);
            start         = (r == 0) || (r == start2);
            hold          = hold_pat[r];
            pf_if.pf_full = full_pat[r];
            if (r == 1) begin
                for (int i = 0; i < N; i++) act_bus[i*W +: W] = W'($urandom);
                en_bus  = {$urandom, $urandom};
                thr_bus = W'($urandom);
            end
            #1;
            if (pf_if.rec_us_prefix_valid) begin
                s_cyc.push_back(r);
                s_dat.push_back(pf_if.rec_us_pf_datain);
            end
            if (done) d_cyc.push_back(r);
            if (err)  e_cyc.push_back(r);
            if (r == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid",  pf_if.rec_us_prefix_valid, 0);
                check("rst_datain", pf_if.rec_us_pf_datain, 0);
                check("rst_busy",   busy, 0);
                check("rst_done",   done, 0);
                check("rst_err",    err, 0);
                check("rst_cnt",    cnt, 0);
                check("rst_idx",    idx_bus, 0);
                check("rst_val",    val_bus, 0);
                break;
            end
        end
        start         = 1'b0;
        hold          = 1'b0;
        pf_if.pf_full = 1'b0;
    endtask

    task automatic check_case(input string name);
        int         nw, good, r, w, exp_done, exp_err;
        logic [8:0] exp_word;
        model_topk();
        nw   = (exp_cnt == 0) ? 1 : exp_cnt;
        good = 0;
        r    = 1;
        while (good < S && r < HORIZON) begin
            if (!hold_pat[r]) good++;
            r++;
        end
        w = 0;
        while (w < nw && r < HORIZON) begin
            if (!hold_pat[r] && !full_pat[r]) begin
                exp_word = (exp_cnt == 0) ? 9'h1FF : {(w == nw - 1) ? 1'b1 : 1'b0, exp_idx[w][7:0]};
                if (w < s_cyc.size()) begin
                    check({name, "_strobe_cyc"}, s_cyc[w], r);
                    check({name, "_strobe_dat"}, s_dat[w], exp_word);
                end
                w++;
            end
            r++;
        end
        exp_done = r;
        exp_err  = (start2 >= 1 && start2 < exp_done && !hold_pat[start2]) ? 1 : 0;
        check({name, "_nstrobe"}, s_cyc.size(), nw);
        check({name, "_ndone"}, d_cyc.size(), 1);
        if (d_cyc.size() > 0) check({name, "_done_cyc"}, d_cyc[0], exp_done);
        check({name, "_nerr"}, e_cyc.size(), exp_err);
        if (exp_err == 1 && e_cyc.size() > 0) check({name, "_err_cyc"}, e_cyc[0], start2 + 1);
        check({name, "_cnt"}, cnt, exp_cnt);
        for (int k = 0; k < K; k++) begin
            check({name, "_idx"}, idx_bus[k*8 +: 8], exp_idx[k]);
            check({name, "_val"}, val_bus[k*W +: W], exp_val[k]);
        end
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; pf_if.pf_full = 1'b0;
        act_bus = '0; en_bus = '0; thr_bus = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",  busy, 0);
        check("reset_valid", pf_if.rec_us_prefix_valid, 0);
        check("reset_cnt",   cnt, 0);
        check("reset_idx",   idx_bus, 0);
        check("reset_val",   val_bus, 0);
        check("reset_done",  done, 0);
        check("reset_err",   err, 0);
        rst_n = 1'b1;

        clear_pats(); load_ramp();
        run_case(); check_case("ramp");

        clear_pats();
        for (int i = 0; i < N; i++) m_act[i] = -8'sd5;
        m_en = '1; m_thr = '0;
        run_case(); check_case("nomatch");

        clear_pats();
        for (int i = 0; i < N; i++) m_act[i] = '0;
        m_act[5] = 8'sd100; m_act[40] = 8'sd100; m_act[41] = 8'sd100;
        m_en = '1; m_thr = 8'sd10;
        run_case(); check_case("tie");

        clear_pats(); load_ramp();
        for (int r = 9; r <= 11; r++) full_pat[r] = 1'b1;
        run_case(); check_case("full");

        clear_pats(); load_ramp();
        hold_pat[3] = 1'b1; hold_pat[4] = 1'b1; start2 = 5;
        run_case(); check_case("hold");

        clear_pats(); load_ramp();
        m_en[63] = 1'b0; rst_cyc = 9;
        run_case();
        check("prerst_nstrobe", s_dat.size(), 1);
        if (s_dat.size() > 0) check("prerst_dat", s_dat[0], 9'h03E);
        @(negedge clk);
        rst_n = 1'b1;
        rst_cyc = -1;
        run_case(); check_case("after_rst");

        for (int t = 0; t < 10; t++) begin
            clear_pats();
            for (int i = 0; i < N; i++) m_act[i] = W'(int'($urandom_range(0, 24)) - 8);
            m_en  = {$urandom, $urandom} | {$urandom, $urandom};
            m_thr = W'(int'($urandom_range(0, 16)) - 4);
            if (t % 3 == 1) for (int r = 9; r < 30; r++) full_pat[r] = ($urandom_range(0, 2) == 0);
            if (t % 3 == 2) for (int r = 1; r < 21; r++) hold_pat[r] = ($urandom_range(0, 5) == 0);
            if (t % 2 == 1) start2 = $urandom_range(2, 8);
            run_case(); check_case("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
